// File: rtl/thermo_pkg.sv
// Shared definitions for the thermometer-code capture front end:
// default widths, buffer state encoding and the code-validity check.
package thermo_pkg;

  localparam int WIDTH_DEF     = 15;
  localparam int ERR_CNT_W_DEF = 8;
  localparam int MAX_W         = 64;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // A code of the form 0..01..1 plus one is a power of two, so it shares no set bit with itself.
  function automatic logic is_thermo(input logic [MAX_W-1:0] code);
    return ((code & (code + 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/thermo_bubble_fix.sv
// Combinational bubble corrector: 3-input majority smoothing, falling back
// to a popcount-derived thermometer code when smoothing leaves a bubble.
module thermo_bubble_fix
  import thermo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] code,
  output logic [WIDTH-1:0] corrected,
  output logic             invalid
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH+1:0] ext_s;
  logic [WIDTH-1:0] maj_s;
  logic [WIDTH-1:0] fill_s;
  logic [CNT_W-1:0] ones_s;

  // Virtual bits: below the lowest threshold reads 1, above the highest reads 0.
  assign ext_s = {1'b0, code, 1'b1};

  // Majority of each bit with its two neighbours.
  always_comb begin
    maj_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      maj_s[i] = (ext_s[i] & ext_s[i+1]) | (ext_s[i] & ext_s[i+2]) | (ext_s[i+1] & ext_s[i+2]);
    end
  end

  // Count of set input bits.
  always_comb begin
    ones_s = {CNT_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      ones_s = ones_s + CNT_W'(code[i]);
    end
  end

  // Thermometer code with the lowest ones_s bits set.
  always_comb begin
    fill_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      fill_s[i] = (CNT_W'(i) < ones_s);
    end
  end

  // Prefer the smoothed code; it preserves level when a single bit flipped.
  always_comb begin
    if (is_thermo(MAX_W'(maj_s))) begin
      corrected = maj_s;
    end else begin
      corrected = fill_s;
    end
  end

  assign invalid = !is_thermo(MAX_W'(code));

endmodule

// File: rtl/thermo_capture.sv
// Flash comparator capture: synchronizes the raw thermometer bank, corrects
// bubbles on a sample strobe and holds the result in a one-entry output buffer.
module thermo_capture
  import thermo_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = ERR_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     thermo_raw,
  input  logic                 sample_en,
  input  logic                 out_ready,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     thermo_out,
  output logic                 out_valid,
  output logic                 bubble_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 overrun
);

  localparam logic [0:0] S_EMPTY = EMPTY;
  localparam logic [0:0] S_FULL  = FULL;

  logic [WIDTH-1:0]     sync_r [SYNC_STAGES];
  logic [WIDTH-1:0]     t_s;
  logic [WIDTH-1:0]     corrected_s;
  logic                 invalid_s;
  logic                 accept_s;
  logic                 drop_s;
  logic [0:0]           state_r;
  logic [0:0]           state_next_s;
  logic [WIDTH-1:0]     thermo_out_r;
  logic                 bubble_err_r;
  logic [ERR_CNT_W-1:0] err_count_r;
  logic                 overrun_r;

  // Synchronizer chain for the asynchronous comparator outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= {WIDTH{1'b0}};
      end
    end else begin
      sync_r[0] <= thermo_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  assign t_s = sync_r[SYNC_STAGES-1];

  thermo_bubble_fix #(
    .WIDTH (WIDTH)
  ) u_fix (
    .code      (t_s),
    .corrected (corrected_s),
    .invalid   (invalid_s)
  );

  assign accept_s = sample_en && ((state_r == S_EMPTY) || out_ready);
  assign drop_s   = sample_en && (state_r == S_FULL) && !out_ready;

  // Next buffer state.
  always_comb begin
    state_next_s = S_EMPTY;
    case (state_r)
      S_EMPTY: begin
        if (accept_s) begin
          state_next_s = S_FULL;
        end else begin
          state_next_s = S_EMPTY;
        end
      end
      S_FULL: begin
        if (out_ready && !sample_en) begin
          state_next_s = S_EMPTY;
        end else begin
          state_next_s = S_FULL;
        end
      end
      default: state_next_s = S_EMPTY;
    endcase
  end

  // Buffer state, held code and error bookkeeping; err_clr wins over new events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_EMPTY;
      thermo_out_r <= {WIDTH{1'b0}};
      bubble_err_r <= 1'b0;
      err_count_r  <= {ERR_CNT_W{1'b0}};
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      bubble_err_r <= accept_s && invalid_s;
      if (accept_s) begin
        thermo_out_r <= corrected_s;
      end
      if (err_clr) begin
        err_count_r <= {ERR_CNT_W{1'b0}};
      end else if (accept_s && invalid_s && (err_count_r != {ERR_CNT_W{1'b1}})) begin
        err_count_r <= err_count_r + ERR_CNT_W'(1);
      end
      if (err_clr) begin
        overrun_r <= 1'b0;
      end else if (drop_s) begin
        overrun_r <= 1'b1;
      end
    end
  end

  assign thermo_out = thermo_out_r;
  assign out_valid  = (state_r == S_FULL);
  assign bubble_err = bubble_err_r;
  assign err_count  = err_count_r;
  assign overrun    = overrun_r;

endmodule
